axis_pkt_arbiter: RTL and testbench

Packet-aware arbiter that shares one AXI-Stream output of axis_switch between S_COUNT input ports. It takes per-input request and acknowledge (end-of-packet) strobes and issues a registered one-hot grant plus encoded index. The grant is locked for a whole packet, so frames from different sources never interleave. One instance sits per switch output, e.g. the 4x1 configuration.

---
 rtl/axis_pkt_arbiter_pkg.sv | 16 +
 rtl/axis_pkt_arbiter_priority_encoder.sv | 32 +++
 rtl/axis_pkt_arbiter.sv | 116 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_arbiter_pkg.sv
// Constants and helpers shared by the packet arbiter and the switch that instantiates it.
package axis_pkt_arbiter_pkg;

  localparam int unsigned ARB_TYPE_FIXED = 0;
  localparam int unsigned ARB_TYPE_RR    = 1;
  localparam int unsigned ARB_PRIO_MSB   = 0;
  localparam int unsigned ARB_PRIO_LSB   = 1;

  typedef enum logic [0:0] {StIdle, StGranted} arb_state_e;

  // Select width for an n-way index; a single port still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_priority_encoder.sv
// Priority encoder: reports whether any bit is set, the winning index and its one-hot form.
module axis_pkt_arbiter_priority_encoder
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH             = 4,
  parameter int unsigned LSB_HIGH_PRIORITY = 1,
  parameter int unsigned ENC_WIDTH         = sel_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     bits,
  output logic                 valid,
  output logic [ENC_WIDTH-1:0] encoded,
  output logic [WIDTH-1:0]     unencoded
);

  always_comb begin
    valid     = |bits;
    encoded   = '0;
    unencoded = '0;
    // The last assignment in the scan wins, so scan from the low-priority end.
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (bits[i]) encoded = ENC_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bits[i]) encoded = ENC_WIDTH'(i);
      end
    end
    if (valid) unencoded = WIDTH'(1) << encoded;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-aware arbiter: registered one-hot grant held for a whole packet, fixed or round robin.
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN  = ARB_TYPE_RR,
  parameter int unsigned ARB_BLOCK             = 1,
  parameter int unsigned ARB_BLOCK_ACK         = 1,
  parameter int unsigned ARB_LSB_HIGH_PRIORITY = ARB_PRIO_LSB,
  parameter int unsigned SEL_WIDTH             = sel_width(PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTS-1:0]     request,
  input  logic [PORTS-1:0]     acknowledge,
  output logic [PORTS-1:0]     grant,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant_encoded
);

  arb_state_e           state_q, state_d;
  logic [PORTS-1:0]     grant_q, grant_d;
  logic [SEL_WIDTH-1:0] enc_q, enc_d;
  logic [PORTS-1:0]     rr_mask_q, rr_mask_d;

  logic                 req_valid, msk_valid, sel_valid;
  logic [SEL_WIDTH-1:0] req_enc, msk_enc, sel_enc;
  logic [PORTS-1:0]     req_oh, msk_oh, sel_oh;
  logic                 release_lock;

  axis_pkt_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
    .ENC_WIDTH         (SEL_WIDTH)
  ) u_enc_req (
    .bits      (request),
    .valid     (req_valid),
    .encoded   (req_enc),
    .unencoded (req_oh)
  );

  axis_pkt_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY),
    .ENC_WIDTH         (SEL_WIDTH)
  ) u_enc_masked (
    .bits      (request & rr_mask_q),
    .valid     (msk_valid),
    .encoded   (msk_enc),
    .unencoded (msk_oh)
  );

  always_comb begin
    sel_valid = req_valid;
    sel_enc   = req_enc;
    sel_oh    = req_oh;
    if ((ARB_TYPE_ROUND_ROBIN != 0) && msk_valid) begin
      sel_enc = msk_enc;
      sel_oh  = msk_oh;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    enc_d        = enc_q;
    rr_mask_d    = rr_mask_q;
    release_lock = 1'b0;

    // grant_q is one-hot, so masking with it selects the granted port's strobe.
    unique case (state_q)
      StIdle:    release_lock = 1'b1;
      StGranted: begin
        if (ARB_BLOCK == 0)          release_lock = 1'b1;
        else if (ARB_BLOCK_ACK != 0) release_lock = |(acknowledge & grant_q);
        else                         release_lock = ~|(request & grant_q);
      end
    endcase

    if (release_lock) begin
      if (sel_valid) begin
        state_d = StGranted;
        grant_d = sel_oh;
        enc_d   = sel_enc;
        if (ARB_TYPE_ROUND_ROBIN != 0) begin
          for (int unsigned j = 0; j < PORTS; j++) begin
            rr_mask_d[j] = (ARB_LSB_HIGH_PRIORITY != 0) ? (j > 32'(sel_enc)) : (j < 32'(sel_enc));
          end
        end
      end else begin
        state_d = StIdle;
        grant_d = '0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      enc_q     <= '0;
      rr_mask_q <= '1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      enc_q     <= enc_d;
      rr_mask_q <= rr_mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == StGranted);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench: three arbiter flavours share one stimulus stream and are checked against a model.
module tb_axis_pkt_arbiter;

  localparam int P = 4;
  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] req, ack;
  logic [P-1:0] grant_w [NDUT];
  logic         valid_w [NDUT];
  logic [1:0]   enc_w   [NDUT];

  always #5 clk = ~clk;

  // d0: RR/LSB/block-ack, d1: fixed/MSB/block-ack, d2: RR/LSB/release-on-request-drop
  axis_pkt_arbiter #(
    .PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
    .ARB_LSB_HIGH_PRIORITY(1)
  ) u_d0 (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(grant_w[0]), .grant_valid(valid_w[0]), .grant_encoded(enc_w[0])
  );

  axis_pkt_arbiter #(
    .PORTS(P), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
    .ARB_LSB_HIGH_PRIORITY(0)
  ) u_d1 (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(grant_w[1]), .grant_valid(valid_w[1]), .grant_encoded(enc_w[1])
  );

  axis_pkt_arbiter #(
    .PORTS(P), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
    .ARB_LSB_HIGH_PRIORITY(1)
  ) u_d2 (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(grant_w[2]), .grant_valid(valid_w[2]), .grant_encoded(enc_w[2])
  );

  typedef struct {
    int         k;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] enc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit k_rr  [NDUT] = '{1'b1, 1'b0, 1'b1};
  bit k_back[NDUT] = '{1'b1, 1'b1, 1'b0};

  // Model: RR is a cyclic search starting just after the last granted port.
  bit m_valid [NDUT];
  int m_idx   [NDUT];
  int m_start [NDUT];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit   rel;
    int   pick;
    exp_t e;
    if (rst) begin
      m_valid[k] = 1'b0;
      m_idx[k]   = 0;
      m_start[k] = 0;
    end else begin
      if (!m_valid[k])    rel = 1'b1;
      else if (k_back[k]) rel = ack[m_idx[k]];
      else                rel = !req[m_idx[k]];
      if (rel) begin
        pick = -1;
        if (k_rr[k]) begin
          for (int n = 0; n < P; n++) begin
            int j;
            j = (m_start[k] + n) % P;
            if (pick < 0 && req[j]) pick = j;
          end
        end else begin
          for (int j = 0; j < P; j++) if (req[j]) pick = j;
        end
        if (pick >= 0) begin
          m_valid[k] = 1'b1;
          m_idx[k]   = pick;
          m_start[k] = (pick + 1) % P;
        end else begin
          m_valid[k] = 1'b0;
          m_idx[k]   = 0;
        end
      end
    end
    e.k     = k;
    e.valid = m_valid[k];
    e.grant = m_valid[k] ? 4'(1 << m_idx[k]) : 4'b0000;
    e.enc   = m_valid[k] ? 2'(m_idx[k]) : 2'd0;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ak);
    exp_t e;
    rst = r;
    req = rq;
    ack = ak;
    for (int k = 0; k < NDUT; k++) model_step(k);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("grant[d%0d]", e.k), 32'(grant_w[e.k]), 32'(e.grant));
      check_eq($sformatf("grant_valid[d%0d]", e.k), 32'(valid_w[e.k]), 32'(e.valid));
      check_eq($sformatf("grant_encoded[d%0d]", e.k), 32'(enc_w[e.k]), 32'(e.enc));
    end
  endtask

  function automatic logic [3:0] d0_grant();
    return m_valid[0] ? 4'(1 << m_idx[0]) : 4'b0000;
  endfunction

  initial begin
    rst = 1'b1;
    req = '0;
    ack = '0;
    @(posedge clk);
    #1;

    // Reset held with all requesting, then first grant.
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b0000);
    check_eq("first_grant_d0", 32'(grant_w[0]), 32'h1);

    // Round robin rotation with an ack on the granted port every cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, d0_grant());

    // Steer d0 onto port 2, then hold the lock across request drop and foreign acks.
    for (int i = 0; i < 8; i++) begin
      if (m_valid[0] && m_idx[0] == 2) break;
      step(1'b0, 4'b1111, d0_grant());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1011, 4'b0001);
    check_eq("lock_held_d0", 32'(grant_w[0]), 32'h4);
    step(1'b0, 4'b1011, 4'b0100);
    check_eq("after_release_d0", 32'(grant_w[0]), 32'h8);
    step(1'b0, 4'b1011, 4'b0000);

    // Fixed MSB priority: acking d1's grant keeps port 2 winning over port 0.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0101, m_valid[1] ? 4'(1 << m_idx[1]) : 4'b0000);
    end
    check_eq("fixed_starve_d1", 32'(grant_w[1]), 32'h4);

    // Sole requester regranted back to back.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, 4'b0010 | d0_grant());
    check_eq("sole_req_d0", 32'(grant_w[0]), 32'h2);

    // Park d0 on port 3, reset mid-packet, then confirm the mask restart.
    step(1'b0, 4'b1000, d0_grant());
    step(1'b0, 4'b1000, 4'b0000);
    step(1'b0, 4'b1000, 4'b0000);
    step(1'b1, 4'b1000, 4'b0000);
    step(1'b0, 4'b1001, 4'b0000);
    check_eq("post_reset_d0", 32'(grant_w[0]), 32'h1);

    // Random traffic, including idle cycles and acks on non-granted ports.
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
